sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO buffering byte/word streams between the UART/RF datapath stages of the transceiver. Unlike the previous edge-triggered buffer, it runs entirely in the `clk` domain and supports any depth (not only powers of two). Reads are first-word-fall-through, with the head word always visible on `rd_data`. It adds simultaneous read/write when full, sticky overflow/underflow flags, an element count, and optional watermark flags.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 32: storage entries, any integer ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`: width of `count`.
- `AF_LEVEL`, `DEPTH-2`: `almost_full` asserts when `count >= AF_LEVEL`. Range 1..DEPTH.
- `AE_LEVEL`, 2: `almost_empty` asserts when `count <= AE_LEVEL`. Range 0..DEPTH-1.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: push request.
- `wr_data` in WIDTH: word to push.
- `rd_en` in 1: pop request.
- `rd_data` out WIDTH: head word; valid while `empty=0`.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `count` out CNT_W: number of stored words.
- `almost_full` out 1: watermark flag (see Configuration).
- `almost_empty` out 1: watermark flag (see Configuration).
- `overflow` out 1: sticky; a push was rejected.
- `underflow` out 1: sticky; a pop was rejected.
- `clr_err` in 1: synchronous clear of `overflow` and `underflow`.

## Operation
- **State:** storage array `mem[0..DEPTH-1]`; `wr_ptr` and `rd_ptr`, each in 0..DEPTH-1; registered `count`. The storage array is not reset.
- **Pointer advance:** ptr ← (ptr == DEPTH-1) ? 0 : ptr+1. Explicit wrap; no power-of-two arithmetic.
- **Read accept:** `rd_ok = rd_en & ~empty`.
- **Write accept:** `wr_ok = wr_en & (~full | rd_ok)`. A write to a full FIFO is accepted only when a pop is accepted in the same cycle.
- **On `wr_ok`:** `mem[wr_ptr] ← wr_data`; advance `wr_ptr`.
- **On `rd_ok`:** advance `rd_ptr`.
- **Count update:** +1 if `wr_ok & ~rd_ok`; −1 if `rd_ok & ~wr_ok`; otherwise unchanged. Never exceeds DEPTH and never wraps.
- **Empty with `wr_en` & `rd_en`:** write accepted, read rejected, `underflow` set. The new word appears on `rd_data` next cycle.
- **Error flags:**
  - `overflow` ← 1 when `wr_en & ~wr_ok`.
  - `underflow` ← 1 when `rd_en & ~rd_ok`.
  - `clr_err` clears both flags. A same-cycle set takes priority over clear.
- **Read path:** `rd_data = mem[rd_ptr]`, combinational. The value is unspecified while `empty=1`.
- **Flag derivation:** `full`, `empty`, `almost_*` decode combinationally from the registered `count`.

## Timing
- **Reset values:** `count=0`, `empty=1`, `full=0`, `almost_empty=1`, `overflow=0`, `underflow=0`. Both pointers are 0. `almost_full=0`, or `=0` per the macro-off tie. `rd_data` is unspecified.
- **Reset mid-operation:** asserting `rst_n` low discards all contents immediately, asynchronously. Release is synchronised externally; the first accepted op is on the first edge after release.
- **Write latency:** a word written at edge N is visible on `rd_data` (if it is the head) and counted after edge N. `empty` falls in the cycle following edge N.
- **Pop latency:** after an accepted pop at edge N, the next word is on `rd_data` after edge N. No bubble; full throughput of 1 push + 1 pop per cycle.
- **Flag timing:** flags and `count` change only on clock edges, except at asynchronous reset.

## Configuration
- Macro `SYNC_FIFO_WATERMARK_EN`.
- **Defined:** `almost_full` and `almost_empty` follow the `AF_LEVEL`/`AE_LEVEL` comparisons on `count`.
- **Undefined:** no comparators are built, and `AF_LEVEL`/`AE_LEVEL` are ignored. `almost_full` = `full` and `almost_empty` = `empty`. The port list is unchanged.

## Test plan
- **Reset check:** reset, then idle → `empty=1`, `full=0`, `count=0`, `overflow=0`, `underflow=0`, `almost_empty=1`.
- **Fill/drain, DEPTH=5, WIDTH=8:** write 0x10..0x14 → `full=1`, `count=5`. A 6th write of 0xFF → `overflow=1`, `count` stays 5. Read 5 → data 0x10..0x14 in order, then `empty=1`.
- **Wrap:** DEPTH=5; loop 12 times, writing 1 word and reading 1 word per cycle (skewed so `count` stays at 1) → data intact across pointer wrap, `count` never exceeds 1.
- **Full plus simultaneous rd/wr:** while full, assert `wr_en` & `rd_en` with 0xAA → head popped, 0xAA accepted, `count` stays DEPTH, `overflow` stays 0.
- **Empty plus simultaneous rd/wr:** while empty, assert `wr_en` & `rd_en` with 0x55 → `underflow=1`, `count=1`, `rd_data=0x55` next cycle. Then `clr_err` → both error flags 0.
- **Watermarks, macro defined, DEPTH=8, AF=6, AE=2:** `almost_empty` is 1 for `count` 0..2 and `almost_full` is 1 for `count` 6..8. Rerun with the macro undefined → the almost flags mirror `full`/`empty`.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO, any DEPTH >= 2, with count, sticky error flags and watermarks.
// `define SYNC_FIFO_WATERMARK_EN to build AF_LEVEL/AE_LEVEL comparators; otherwise almost_* mirror full/empty.
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_ok, wr_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  always_comb begin
    rd_ok       = rd_en & ~empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wr_ok       = wr_en & (~full | rd_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d  = (wr_en & ~wr_ok) | (overflow_q & ~clr_err);
    underflow_d = (rd_en & ~rd_ok) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef SYNC_FIFO_WATERMARK_EN
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
`else
  assign almost_full  = full;
  assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a DEPTH=5 and a DEPTH=8 instance checked against a queue-based model.
module tb_sync_fifo;
  localparam int D0 = 5, D1 = 8;
  localparam int AF0 = 3, AE0 = 1, AF1 = 6, AE1 = 2;

  int dep [2] = '{D0, D1};
  int afl [2] = '{AF0, AF1};
  int ael [2] = '{AE0, AE1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       wr_en_a [2];
  logic       rd_en_a [2];
  logic       clr_a   [2];
  logic [7:0] wdat_a  [2];
  logic [7:0] rdat_a  [2];
  logic       full_a  [2];
  logic       empty_a [2];
  logic       af_a    [2];
  logic       ae_a    [2];
  logic       ovf_a   [2];
  logic       unf_a   [2];
  logic [3:0] count_a [2];
  logic [2:0] cnt5;
  logic [3:0] cnt8;

  typedef logic [7:0] byteq_t [$];
  byteq_t mq [2];
  bit mov [2];
  bit mun [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(D0), .AF_LEVEL(AF0), .AE_LEVEL(AE0)) u5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a[0]), .wr_data(wdat_a[0]), .rd_en(rd_en_a[0]),
    .rd_data(rdat_a[0]), .full(full_a[0]), .empty(empty_a[0]), .count(cnt5),
    .almost_full(af_a[0]), .almost_empty(ae_a[0]), .overflow(ovf_a[0]), .underflow(unf_a[0]),
    .clr_err(clr_a[0]));

  sync_fifo #(.WIDTH(8), .DEPTH(D1), .AF_LEVEL(AF1), .AE_LEVEL(AE1)) u8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a[1]), .wr_data(wdat_a[1]), .rd_en(rd_en_a[1]),
    .rd_data(rdat_a[1]), .full(full_a[1]), .empty(empty_a[1]), .count(cnt8),
    .almost_full(af_a[1]), .almost_empty(ae_a[1]), .overflow(ovf_a[1]), .underflow(unf_a[1]),
    .clr_err(clr_a[1]));

  assign count_a[0] = {1'b0, cnt5};
  assign count_a[1] = cnt8;

  // Expected {full, empty, almost_full, almost_empty, overflow, underflow, count} from the model.
  function automatic logic [9:0] exp_flags(int i);
    int n;
    logic ef, ee, eaf, eae;
    n   = mq[i].size();
    ef  = (n == dep[i]);
    ee  = (n == 0);
`ifdef SYNC_FIFO_WATERMARK_EN
    eaf = (n >= afl[i]);
    eae = (n <= ael[i]);
`else
    eaf = ef;
    eae = ee;
`endif
    return {ef, ee, eaf, eae, mov[i], mun[i], 4'(n)};
  endfunction

  function automatic logic [9:0] obs_flags(int i);
    return {full_a[i], empty_a[i], af_a[i], ae_a[i], ovf_a[i], unf_a[i], count_a[i]};
  endfunction

  function automatic void model_upd(int i, bit we, bit re, logic [7:0] d, bit ce);
    bit rok, wok;
    rok = re && (mq[i].size() > 0);
    wok = we && ((mq[i].size() < dep[i]) || rok);
    if (rok) void'(mq[i].pop_front());
    if (wok) mq[i].push_back(d);
    if (we && !wok) mov[i] = 1'b1; else if (ce) mov[i] = 1'b0;
    if (re && !rok) mun[i] = 1'b1; else if (ce) mun[i] = 1'b0;
  endfunction

  task automatic step(int i, bit we, bit re, logic [7:0] d, bit ce);
    wr_en_a[i] = we; rd_en_a[i] = re; wdat_a[i] = d; clr_a[i] = ce;
    model_upd(i, we, re, d, ce);
    @(posedge clk); #1;
    wr_en_a[i] = 1'b0; rd_en_a[i] = 1'b0; clr_a[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      wr_en_a[i] = 0; rd_en_a[i] = 0; clr_a[i] = 0; wdat_a[i] = 0;
      mq[i].delete(); mov[i] = 0; mun[i] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      // full=0 empty=1 af=0 ae=1 ovf=0 unf=0 count=0
      if (obs_flags(i) !== 10'b01_01_00_0000) begin
        failures++;
        $display("FAIL reset_state fifo%0d got=%b want=%b", i, obs_flags(i), 10'b0101000000);
      end
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'h10 + 8'(k), 0);
    checks++;
    if (full_a[0] !== 1'b1 || count_a[0] !== 4'd5) begin
      failures++;
      $display("FAIL fill_full got full=%b count=%0d want full=1 count=5", full_a[0], count_a[0]);
    end
    step(0, 1, 0, 8'hFF, 0);
    checks++;
    if (ovf_a[0] !== 1'b1 || count_a[0] !== 4'd5) begin
      failures++;
      $display("FAIL overflow_set got ovf=%b count=%0d want ovf=1 count=5", ovf_a[0], count_a[0]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rdat_a[0] !== 8'h10 + 8'(k)) begin
        failures++;
        $display("FAIL drain_data[%0d] got=%h want=%h", k, rdat_a[0], 8'h10 + 8'(k));
      end
      step(0, 0, 1, 8'h00, 0);
    end
    checks++;
    if (empty_a[0] !== 1'b1 || obs_flags(0) !== exp_flags(0)) begin
      failures++;
      $display("FAIL drain_empty got=%b want=%b", obs_flags(0), exp_flags(0));
    end
    step(0, 0, 0, 8'h00, 1);
  endtask

  task automatic test_wrap();
    step(0, 1, 0, 8'h80, 0);
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (rdat_a[0] !== 8'h80 + 8'(k - 1) || count_a[0] !== 4'd1) begin
        failures++;
        $display("FAIL wrap[%0d] got data=%h count=%0d want data=%h count=1",
                 k, rdat_a[0], count_a[0], 8'h80 + 8'(k - 1));
      end
      step(0, 1, 1, 8'h80 + 8'(k), 0);
    end
    checks++;
    if (rdat_a[0] !== 8'h8C || ovf_a[0] !== 1'b0 || unf_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_tail got data=%h ovf=%b unf=%b want 8c 0 0", rdat_a[0], ovf_a[0], unf_a[0]);
    end
    step(0, 0, 1, 8'h00, 0);
  endtask

  task automatic test_full_rdwr();
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'h20 + 8'(k), 0);
    step(0, 1, 1, 8'hAA, 0);
    checks++;
    if (count_a[0] !== 4'd5 || ovf_a[0] !== 1'b0 || full_a[0] !== 1'b1 || rdat_a[0] !== 8'h21) begin
      failures++;
      $display("FAIL full_rdwr got count=%0d ovf=%b full=%b head=%h want 5 0 1 21",
               count_a[0], ovf_a[0], full_a[0], rdat_a[0]);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rdat_a[0] !== mq[0][0]) begin
        failures++;
        $display("FAIL full_rdwr_drain[%0d] got=%h want=%h", k, rdat_a[0], mq[0][0]);
      end
      step(0, 0, 1, 8'h00, 0);
    end
  endtask

  task automatic test_empty_rdwr();
    step(0, 1, 1, 8'h55, 0);
    checks++;
    if (unf_a[0] !== 1'b1 || count_a[0] !== 4'd1 || rdat_a[0] !== 8'h55 || empty_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL empty_rdwr got unf=%b count=%0d data=%h empty=%b want 1 1 55 0",
               unf_a[0], count_a[0], rdat_a[0], empty_a[0]);
    end
    step(0, 0, 0, 8'h00, 1);
    checks++;
    if (unf_a[0] !== 1'b0 || ovf_a[0] !== 1'b0 || count_a[0] !== 4'd1) begin
      failures++;
      $display("FAIL clr_err got unf=%b ovf=%b count=%0d want 0 0 1", unf_a[0], ovf_a[0], count_a[0]);
    end
    step(0, 0, 1, 8'h00, 0);
  endtask

  task automatic test_watermark();
    bit waf, wae;
    for (int k = 0; k <= 8; k++) begin
`ifdef SYNC_FIFO_WATERMARK_EN
      waf = (k >= 6); wae = (k <= 2);
`else
      waf = (k == 8); wae = (k == 0);
`endif
      checks++;
      if (af_a[1] !== waf || ae_a[1] !== wae || count_a[1] !== 4'(k)) begin
        failures++;
        $display("FAIL watermark_up[%0d] got af=%b ae=%b count=%0d want %b %b %0d",
                 k, af_a[1], ae_a[1], count_a[1], waf, wae, k);
      end
      if (k < 8) step(1, 1, 0, 8'($urandom), 0);
    end
    for (int k = 8; k > 0; k--) begin
      step(1, 0, 1, 8'h00, 0);
      checks++;
      if (obs_flags(1) !== exp_flags(1)) begin
        failures++;
        $display("FAIL watermark_down[%0d] got=%b want=%b", k - 1, obs_flags(1), exp_flags(1));
      end
    end
  endtask

  task automatic test_random();
    bit we, re, ce;
    logic [7:0] d;
    int wp;
    for (int c = 0; c < 1500; c++) begin
      wp = ((c / 60) % 2 == 0) ? 70 : 30;
      for (int i = 0; i < 2; i++) begin
        we = ($urandom % 100) < wp;
        re = ($urandom % 100) < (100 - wp);
        ce = ($urandom % 20) == 0;
        d  = 8'($urandom);
        wr_en_a[i] = we; rd_en_a[i] = re; wdat_a[i] = d; clr_a[i] = ce;
        model_upd(i, we, re, d, ce);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_flags(i) !== exp_flags(i)) begin
          failures++;
          $display("FAIL random_flags fifo%0d cyc%0d got=%b want=%b", i, c, obs_flags(i), exp_flags(i));
        end
        if (mq[i].size() > 0) begin
          checks++;
          if (rdat_a[i] !== mq[i][0]) begin
            failures++;
            $display("FAIL random_data fifo%0d cyc%0d got=%h want=%h", i, c, rdat_a[i], mq[i][0]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      wr_en_a[i] = 0; rd_en_a[i] = 0; clr_a[i] = 0;
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      wr_en_a[0] = 1; wr_en_a[1] = 1; wdat_a[0] = 8'(k); wdat_a[1] = 8'(k);
      model_upd(0, 1, 0, 8'(k), 0);
      model_upd(1, 1, 0, 8'(k), 0);
      @(posedge clk); #1;
    end
    wr_en_a[0] = 0; wr_en_a[1] = 0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete(); mov[i] = 0; mun[i] = 0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_flags(i) !== exp_flags(i) || empty_a[i] !== 1'b1) begin
        failures++;
        $display("FAIL async_reset fifo%0d got=%b want=%b", i, obs_flags(i), exp_flags(i));
      end
    end
    @(negedge clk) rst_n = 1'b1;
    step(1, 1, 0, 8'hC3, 0);
    checks++;
    if (count_a[1] !== 4'd1 || rdat_a[1] !== 8'hC3) begin
      failures++;
      $display("FAIL post_reset_write got count=%0d data=%h want 1 c3", count_a[1], rdat_a[1]);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rdwr();
    test_empty_rdwr();
    test_watermark();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
